// File: rtl/mac_pipe_if.sv
// mac_pipe sample/result bus.
// master drives the sample side and receives results; slave is the pipeline.
interface mac_pipe_if #(
  parameter int P = 8,
  parameter int G = 4
);
  localparam int W = 2*P + G;

  logic         IN_VALID;
  logic         MODE;
  logic         ACC_CLR;
  logic [P-1:0] A1;
  logic [P-1:0] B1;
  logic [P-1:0] C1;
  logic         OUT_VALID;
  logic [W-1:0] DATA_OUT;
  logic         OVF;

  modport master (
    output IN_VALID, MODE, ACC_CLR, A1, B1, C1,
    input  OUT_VALID, DATA_OUT, OVF
  );

  modport slave (
    input  IN_VALID, MODE, ACC_CLR, A1, B1, C1,
    output OUT_VALID, DATA_OUT, OVF
  );
endinterface

// File: rtl/mac_pipe.sv
// mac_pipe: 3-stage multiply-add / multiply-accumulate pipeline.
// Stage 1 registers the sample, stage 2 computes the product and the sum and
// owns the accumulator, stage 3 presents the result. Latency 2 edges after
// sampling, one sample per clock.
// Optional macro MAC_PIPE_SAT_EN: clamp accumulate-mode overflow to the
// W-bit extreme instead of wrapping.
module mac_pipe #(
  parameter int P      = 8,
  parameter int G      = 4,
  parameter int SIGNED = 0
) (
  input  logic       C,
  input  logic       RST_n,
  mac_pipe_if.slave  bus
);
  localparam int W = 2*P + G;

  logic         s1_valid_q, s1_mode_q, s1_clr_q;
  logic [P-1:0] s1_a_q, s1_b_q, s1_c_q;

  logic         s2_valid_q, s2_ovf_q;
  logic [W-1:0] s2_res_q, acc_q;

  logic         out_valid_q, out_ovf_q;
  logic [W-1:0] out_data_q;

  logic [W-1:0] a_x, b_x, c_x, prod_w, base, res_d, acc_d;
  logic [W:0]   sum;
  logic         ovf_d;

  // Stage 1: register the incoming sample unconditionally
  always_ff @(posedge C or negedge RST_n) begin
    if (!RST_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else begin
      s1_valid_q <= bus.IN_VALID;
      s1_mode_q  <= bus.MODE;
      s1_clr_q   <= bus.ACC_CLR;
      s1_a_q     <= bus.A1;
      s1_b_q     <= bus.B1;
      s1_c_q     <= bus.C1;
    end
  end

  // Operand extension to the full result width; a W-bit product of extended
  // operands equals the extended 2P-bit product since the product fits 2P bits
  always_comb begin
    if (SIGNED != 0) begin
      a_x = W'($signed(s1_a_q));
      b_x = W'($signed(s1_b_q));
      c_x = W'($signed(s1_c_q));
    end else begin
      a_x = W'(s1_a_q);
      b_x = W'(s1_b_q);
      c_x = W'(s1_c_q);
    end
  end

  assign prod_w = a_x * b_x;
  assign base   = s1_clr_q ? '0 : acc_q;
  assign sum    = {1'b0, base} + {1'b0, prod_w};

  // Stage 2 result, overflow and next accumulator value
  always_comb begin
    res_d = prod_w + c_x;
    ovf_d = 1'b0;
    acc_d = acc_q;
    if (s1_mode_q) begin
      res_d = sum[W-1:0];
      if (SIGNED != 0)
        ovf_d = (base[W-1] == prod_w[W-1]) && (sum[W-1] != base[W-1]);
      else
        ovf_d = sum[W];
`ifdef MAC_PIPE_SAT_EN
      // Signed overflow direction follows the common operand sign
      if (ovf_d) begin
        if (SIGNED == 0)
          res_d = '1;
        else if (base[W-1])
          res_d = {1'b1, {(W-1){1'b0}}};
        else
          res_d = {1'b0, {(W-1){1'b1}}};
      end
`endif
      if (s1_valid_q)
        acc_d = res_d;
    end
  end

  // Stage 2 registers; acc_q updates on the same edge, so the next sample
  // sitting in stage 1 already sees it (back-to-back chaining)
  always_ff @(posedge C or negedge RST_n) begin
    if (!RST_n) begin
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_ovf_q   <= 1'b0;
      acc_q      <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      acc_q      <= acc_d;
      if (s1_valid_q) begin
        s2_res_q <= res_d;
        s2_ovf_q <= ovf_d;
      end
    end
  end

  // Stage 3: present results; data and flag hold between valid results
  always_ff @(posedge C or negedge RST_n) begin
    if (!RST_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= s2_res_q;
        out_ovf_q  <= s2_ovf_q;
      end
    end
  end

  assign bus.OUT_VALID = out_valid_q;
  assign bus.DATA_OUT  = out_data_q;
  assign bus.OVF       = out_ovf_q;
endmodule
